// File: rtl/mem_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr_if
// Bundles the requester-side handshake and the external memory bus of the
// round-robin memory arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives the
//            memory strobe/address/data and per-port results)
//   master : environment view (requesters plus memory controller)
// Signals:
//   reqtoggle/reqwe/reqbe/reqaddr/reqdatain : per-port request, flattened
//   reqdataout/reqdone/alldone/reqerr       : per-port results
//   memcs/memrw/membe/memaddr/memdatawrite  : memory access
//   memdataread/memdone                     : memory response
// ---------------------------------------------------------------------------
interface mem_arbiter_rr_if #(
  parameter int NPORT = 2,
  parameter int AW    = 22,
  parameter int DW    = 32,
  parameter int BW    = 4
);
  logic [NPORT-1:0]    reqtoggle;
  logic [NPORT-1:0]    reqwe;
  logic [NPORT*BW-1:0] reqbe;
  logic [NPORT*AW-1:0] reqaddr;
  logic [NPORT*DW-1:0] reqdatain;
  logic [NPORT*DW-1:0] reqdataout;
  logic [NPORT-1:0]    reqdone;
  logic                alldone;
  logic [NPORT-1:0]    reqerr;
  logic                memcs;
  logic                memrw;
  logic [BW-1:0]       membe;
  logic [AW-1:0]       memaddr;
  logic [DW-1:0]       memdatawrite;
  logic [DW-1:0]       memdataread;
  logic                memdone;

  modport slave (
    input  reqtoggle, reqwe, reqbe, reqaddr, reqdatain, memdataread, memdone,
    output reqdataout, reqdone, alldone, reqerr,
           memcs, memrw, membe, memaddr, memdatawrite
  );

  modport master (
    output reqtoggle, reqwe, reqbe, reqaddr, reqdatain, memdataread, memdone,
    input  reqdataout, reqdone, alldone, reqerr,
           memcs, memrw, membe, memaddr, memdatawrite
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
// N-port round-robin arbiter sharing one external memory bus. Each port
// raises a request by toggling its reqtoggle line; the request is latched
// into per-port holding registers and served in round-robin order with a
// one-cycle memcs strobe, completing on a rising edge of memdone or, when
// TIMEOUT is non-zero, after TIMEOUT cycles with a sticky error flag.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : mem_arbiter_rr_if.slave (request side and memory bus)
// ---------------------------------------------------------------------------
module mem_arbiter_rr #(
  parameter int NPORT   = 2,
  parameter int AW      = 22,
  parameter int DW      = 32,
  parameter int BW      = 4,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rstn,
  mem_arbiter_rr_if.slave bus
);

  localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;
  // Last counter value before a forced completion; unused when TIMEOUT is 0.
  localparam logic [15:0] TLIM = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Returns {valid, index} of the first set bit of pend scanning start,
  // start+1, ... modulo NPORT. Scanning backwards lets the nearest hit win.
  function automatic logic [GW:0] pick_grant(input logic [NPORT-1:0] pend,
                                             input logic [GW-1:0]    start);
    logic [GW:0] res;
    int          idx;
    res = {(GW+1){1'b0}};
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NPORT;
      if (pend[idx]) begin
        res = {1'b1, GW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Per-port request tracking
  logic [NPORT-1:0] toggle_q_r;
  logic             primed_r;
  logic [NPORT-1:0] pending_r;
  logic [NPORT-1:0] reqdone_r;
  logic [NPORT-1:0] reqerr_r;
  logic [NPORT-1:0] hold_we_r;
  logic [BW-1:0]    hold_be_r   [NPORT];
  logic [AW-1:0]    hold_addr_r [NPORT];
  logic [DW-1:0]    hold_data_r [NPORT];

  // Access sequencing
  state_t           state_r;
  logic [GW-1:0]    grant_r;
  logic [GW-1:0]    rr_r;
  logic             memdone_q_r;
  logic [15:0]      tcnt_r;
  logic             memcs_r;
  logic             memrw_r;
  logic [BW-1:0]    membe_r;
  logic [AW-1:0]    memaddr_r;
  logic [DW-1:0]    memdatawrite_r;
  logic [NPORT*DW-1:0] reqdataout_r;

  logic             done_rise_s;
  logic             timeout_hit_s;
  logic             complete_s;
  logic [NPORT-1:0] comp_vec_s;
  logic [NPORT-1:0] toggle_s;
  logic [NPORT-1:0] accept_s;
  logic [NPORT-1:0] overrun_s;
  logic [GW:0]      pick_s;

  // Completion, toggle detection and next-grant selection.
  always_comb begin
    done_rise_s   = bus.memdone & ~memdone_q_r;
    timeout_hit_s = 1'b0;
    complete_s    = 1'b0;
    comp_vec_s    = {NPORT{1'b0}};
    if (state_r == ST_WAIT) begin
      // A real memdone edge takes precedence over a coincident timeout.
      if ((TIMEOUT != 0) && (tcnt_r == TLIM) && !done_rise_s) begin
        timeout_hit_s = 1'b1;
      end else begin
        timeout_hit_s = 1'b0;
      end
      complete_s = done_rise_s | timeout_hit_s;
    end else begin
      complete_s = 1'b0;
    end
    if (complete_s) begin
      comp_vec_s[grant_r] = 1'b1;
    end else begin
      comp_vec_s = {NPORT{1'b0}};
    end
    // Nothing is detected on the priming edge, so reset-time levels are ignored.
    if (primed_r) begin
      toggle_s = bus.reqtoggle ^ toggle_q_r;
    end else begin
      toggle_s = {NPORT{1'b0}};
    end
    // A port completing this edge may accept its next request immediately.
    accept_s  = toggle_s & (~pending_r | comp_vec_s);
    overrun_s = toggle_s & pending_r & ~comp_vec_s;
    pick_s    = pick_grant(pending_r, rr_r);
  end

  // Per-port pending/done/error flags and request holding registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      toggle_q_r <= {NPORT{1'b0}};
      primed_r   <= 1'b0;
      pending_r  <= {NPORT{1'b0}};
      reqdone_r  <= {NPORT{1'b1}};
      reqerr_r   <= {NPORT{1'b0}};
      hold_we_r  <= {NPORT{1'b0}};
      for (int i = 0; i < NPORT; i++) begin
        hold_be_r[i]   <= {BW{1'b0}};
        hold_addr_r[i] <= {AW{1'b0}};
        hold_data_r[i] <= {DW{1'b0}};
      end
    end else begin
      toggle_q_r <= bus.reqtoggle;
      primed_r   <= 1'b1;
      // Set wins over clear when a port completes and re-requests together.
      pending_r  <= (pending_r & ~comp_vec_s) | accept_s;
      reqdone_r  <= (reqdone_r | comp_vec_s) & ~accept_s;
      reqerr_r   <= reqerr_r | overrun_s |
                    (timeout_hit_s ? comp_vec_s : {NPORT{1'b0}});
      for (int i = 0; i < NPORT; i++) begin
        if (accept_s[i]) begin
          hold_we_r[i]   <= bus.reqwe[i];
          hold_be_r[i]   <= bus.reqbe[i*BW +: BW];
          hold_addr_r[i] <= bus.reqaddr[i*AW +: AW];
          hold_data_r[i] <= bus.reqdatain[i*DW +: DW];
        end
      end
    end
  end

  // IDLE/ISSUE/WAIT access sequencer with registered memory-bus outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= ST_IDLE;
      grant_r        <= {GW{1'b0}};
      rr_r           <= {GW{1'b0}};
      memdone_q_r    <= 1'b0;
      tcnt_r         <= 16'd0;
      memcs_r        <= 1'b0;
      memrw_r        <= 1'b0;
      membe_r        <= {BW{1'b0}};
      memaddr_r      <= {AW{1'b0}};
      memdatawrite_r <= {DW{1'b0}};
      reqdataout_r   <= {(NPORT*DW){1'b0}};
    end else begin
      memdone_q_r <= bus.memdone;
      case (state_r)
        ST_IDLE: begin
          memcs_r <= 1'b0;
          if (pick_s[GW]) begin
            grant_r        <= pick_s[GW-1:0];
            memrw_r        <= hold_we_r[pick_s[GW-1:0]];
            membe_r        <= hold_be_r[pick_s[GW-1:0]];
            memaddr_r      <= hold_addr_r[pick_s[GW-1:0]];
            memdatawrite_r <= hold_we_r[pick_s[GW-1:0]] ?
                              hold_data_r[pick_s[GW-1:0]] : {DW{1'b0}};
            memcs_r        <= 1'b1;
            state_r        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          memcs_r <= 1'b0;
          tcnt_r  <= 16'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          memcs_r <= 1'b0;
          tcnt_r  <= tcnt_r + 16'd1;
          if (complete_s) begin
            // A forced (timeout) completion leaves the read data untouched.
            if (done_rise_s && !memrw_r) begin
              reqdataout_r[grant_r*DW +: DW] <= bus.memdataread;
            end
            rr_r    <= (int'(grant_r) == NPORT - 1) ? {GW{1'b0}} : grant_r + GW'(1'b1);
            state_r <= ST_IDLE;
          end
        end
        default: begin
          memcs_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.memcs        = memcs_r;
  assign bus.memrw        = memrw_r;
  assign bus.membe        = membe_r;
  assign bus.memaddr      = memaddr_r;
  assign bus.memdatawrite = memdatawrite_r;
  assign bus.reqdataout   = reqdataout_r;
  assign bus.reqdone      = reqdone_r;
  assign bus.alldone      = &reqdone_r;
  assign bus.reqerr       = reqerr_r;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rr
// Self-checking bench for mem_arbiter_rr (3 ports, TIMEOUT=8). Directed
// steps cover reset, latency, read/write fields, round-robin order, overrun,
// timeout and mid-access reset; a randomized phase follows. Expectations come
// from a request-level model: per-port pending set, latched requests, a
// round-robin pointer and the last read data per port.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rr;
  localparam int NP = 3;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NPORT(NP), .AW(AW), .DW(DW), .BW(BW)) bus ();

  mem_arbiter_rr #(.NPORT(NP), .AW(AW), .DW(DW), .BW(BW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  bit          m_pend [NP];
  bit          m_err  [NP];
  bit          m_we   [NP];
  logic [3:0]  m_be   [NP];
  logic [21:0] m_addr [NP];
  logic [31:0] m_data [NP];
  logic [31:0] m_dout [NP];
  int          m_rr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = 1'b0;
      m_err[i]  = 1'b0;
      m_dout[i] = 32'h0;
    end
    m_rr = 0;
  endtask

  function automatic logic [NP-1:0] exp_done();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = ~m_pend[i];
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_err();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = m_err[i];
    return r;
  endfunction

  function automatic logic [NP*DW-1:0] exp_dout();
    logic [NP*DW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*DW +: DW] = m_dout[i];
    return r;
  endfunction

  // Round-robin rule: first pending port at or after the pointer.
  function automatic int next_port();
    for (int k = 0; k < NP; k++) begin
      if (m_pend[(m_rr + k) % NP]) return (m_rr + k) % NP;
    end
    return -1;
  endfunction

  // Present a request on port p and flip its toggle line.
  task automatic req(input int p, input bit we, input logic [3:0] be,
                     input logic [21:0] a, input logic [31:0] d);
    bus.reqwe[p]             = we;
    bus.reqbe[p*BW +: BW]    = be;
    bus.reqaddr[p*AW +: AW]  = a;
    bus.reqdatain[p*DW +: DW] = d;
    bus.reqtoggle[p]         = ~bus.reqtoggle[p];
    if (m_pend[p]) begin
      m_err[p] = 1'b1;
    end else begin
      m_pend[p] = 1'b1;
      m_we[p]   = we;
      m_be[p]   = be;
      m_addr[p] = a;
      m_data[p] = d;
    end
  endtask

  // Wait for the strobe, check the access fields, then check it lasts one cycle.
  task automatic wait_cs(input int p, output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.memcs === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("memcs_seen", 128'(lat != 0), 128'(1));
    check("memaddr", 128'(bus.memaddr), 128'(m_addr[p]));
    check("memrw", 128'(bus.memrw), 128'(m_we[p]));
    check("membe", 128'(bus.membe), 128'(m_be[p]));
    check("memdatawrite", 128'(bus.memdatawrite), 128'(m_we[p] ? m_data[p] : 32'h0));
    tick();
    check("memcs_one_cycle", 128'(bus.memcs), 128'(0));
  endtask

  // Raise memdone after dly cycles and check the per-port results.
  task automatic finish_done(input int p, input logic [31:0] rd, input int dly);
    repeat (dly) tick();
    bus.memdataread = rd;
    bus.memdone     = 1'b1;
    tick();
    m_pend[p] = 1'b0;
    if (!m_we[p]) m_dout[p] = rd;
    m_rr = (p + 1) % NP;
    check("reqdone", 128'(bus.reqdone), 128'(exp_done()));
    check("reqdataout", 128'(bus.reqdataout), 128'(exp_dout()));
    check("reqerr", 128'(bus.reqerr), 128'(exp_err()));
    check("alldone", 128'(bus.alldone), 128'(&exp_done()));
    bus.memdone = 1'b0;
  endtask

  task automatic svc(input int p);
    int lat;
    wait_cs(p, lat);
    finish_done(p, $urandom, $urandom_range(0, 3));
  endtask

  initial begin
    int lat;
    int n;
    bit flag;
    int p;
    logic [2:0] mask;

    bus.reqtoggle   = 3'b111;
    bus.reqwe       = 3'b000;
    bus.reqbe       = 12'h0;
    bus.reqaddr     = 66'h0;
    bus.reqdatain   = 96'h0;
    bus.memdataread = 32'h0;
    bus.memdone     = 1'b0;
    model_reset();

    // Reset state, with toggle levels high through release
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_memcs", 128'(bus.memcs), 128'(0));
    check("rst_memrw", 128'(bus.memrw), 128'(0));
    check("rst_membe", 128'(bus.membe), 128'(0));
    check("rst_memaddr", 128'(bus.memaddr), 128'(0));
    check("rst_memdatawrite", 128'(bus.memdatawrite), 128'(0));
    check("rst_reqdataout", 128'(bus.reqdataout), 128'(0));
    check("rst_reqdone", 128'(bus.reqdone), 128'(3'b111));
    check("rst_alldone", 128'(bus.alldone), 128'(1));
    check("rst_reqerr", 128'(bus.reqerr), 128'(0));
    rstn = 1'b1;
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (bus.memcs !== 1'b0) flag = 1'b1;
    end
    check("reset_levels_no_memcs", 128'(flag), 128'(0));
    check("reset_levels_reqdone", 128'(bus.reqdone), 128'(3'b111));

    // Single read on port 1 with latency check
    req(1, 1'b0, 4'hF, 22'h00123, 32'h0);
    wait_cs(1, lat);
    check("read_latency", 128'(lat), 128'(2));
    finish_done(1, 32'hDEADBEEF, 2);
    check("read_data_port1", 128'(bus.reqdataout[63:32]), 128'(32'hDEADBEEF));

    // Write on port 0: byte enables and data driven, read data untouched
    req(0, 1'b1, 4'b0011, 22'h10, 32'hA5A5A5A5);
    wait_cs(0, lat);
    finish_done(0, 32'h12345678, 1);
    check("write_keeps_dout0", 128'(bus.reqdataout[31:0]), 128'(32'h0));

    // Simultaneous requests with rr=1, then ports 2 and 0 with rr=1
    req(0, 1'b0, 4'hF, 22'h100, 32'h0);
    req(1, 1'b1, 4'hC, 22'h200, 32'h11112222);
    req(2, 1'b0, 4'hF, 22'h300, 32'h0);
    svc(1);
    svc(2);
    svc(0);
    req(2, 1'b0, 4'h1, 22'h310, 32'h0);
    req(0, 1'b1, 4'h8, 22'h110, 32'h33334444);
    svc(2);
    svc(0);

    // Overrun: second toggle while pending is dropped and flagged
    req(0, 1'b0, 4'hF, 22'h400, 32'h0);
    tick();
    req(0, 1'b0, 4'hF, 22'h480, 32'h0);
    wait_cs(0, lat);
    check("overrun_err", 128'(bus.reqerr), 128'(exp_err()));
    finish_done(0, 32'hCAFEF00D, 1);
    flag = 1'b0;
    repeat (10) begin
      tick();
      if (bus.memcs !== 1'b0) flag = 1'b1;
    end
    check("overrun_single_access", 128'(flag), 128'(0));

    // Timeout: memdone never rises
    req(1, 1'b0, 4'hF, 22'h500, 32'h0);
    wait_cs(1, lat);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.reqdone[1] === 1'b1) begin
        n = k;
        break;
      end
    end
    check("timeout_cycles", 128'(n), 128'(TO));
    m_pend[1] = 1'b0;
    m_err[1]  = 1'b1;
    m_rr      = 2;
    check("timeout_err", 128'(bus.reqerr), 128'(exp_err()));
    check("timeout_dout", 128'(bus.reqdataout), 128'(exp_dout()));
    check("timeout_done", 128'(bus.reqdone), 128'(exp_done()));

    // Reset in WAIT, then a stale memdone must not complete a new access
    req(2, 1'b0, 4'hF, 22'h600, 32'h0);
    wait_cs(2, lat);
    tick();
    rstn        = 1'b0;
    bus.memdone = 1'b1;
    #1;
    model_reset();
    check("midrst_memcs", 128'(bus.memcs), 128'(0));
    check("midrst_reqdone", 128'(bus.reqdone), 128'(3'b111));
    check("midrst_reqerr", 128'(bus.reqerr), 128'(0));
    check("midrst_alldone", 128'(bus.alldone), 128'(1));
    tick();
    rstn = 1'b1;
    tick();
    req(0, 1'b0, 4'hF, 22'h700, 32'h0);
    wait_cs(0, lat);
    flag = 1'b0;
    repeat (5) begin
      tick();
      if (bus.reqdone[0] !== 1'b0) flag = 1'b1;
    end
    check("stale_memdone_no_complete", 128'(flag), 128'(0));
    bus.memdone = 1'b0;
    tick();
    finish_done(0, 32'h0BADF00D, 0);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int q = 0; q < NP; q++) begin
        if (mask[q]) req(q, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         22'($urandom), $urandom);
      end
      p = next_port();
      while (p >= 0) begin
        svc(p);
        p = next_port();
      end
      check("round_alldone", 128'(bus.alldone), 128'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
